// File: rtl/cpu_types_pkg.sv
// Shared types for the memory-side responder: RAM handshake states,
// data words and the arbiter FSM encoding.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        DGRANT,
        IGRANT,
        TURN
    } memctl_state_t;

    localparam int unsigned TIMEOUT_W = 8;

endpackage

// File: rtl/memctl_timeout.sv
// Grant watchdog: 8-bit cycle counter with synchronous clear/enable and
// an expire flag raised when the count reaches LIMIT.
module memctl_timeout
    import cpu_types_pkg::*;
#(
    parameter logic [TIMEOUT_W-1:0] LIMIT = '1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [TIMEOUT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + TIMEOUT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q == LIMIT);

endmodule

// File: rtl/memory_control.sv
// Arbitrates fetch and data requests onto a single RAM port; data wins ties.
// Handshake outputs are combinational so a completing access is seen the same cycle.
module memory_control
    import cpu_types_pkg::*;
#(
    parameter int unsigned WORD_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [WORD_W-1:0] iload,
    output logic              iwait,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic [WORD_W-1:0] dload,
    output logic              dwait,
    output logic              dhit,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              err
);

    memctl_state_t state_q, state_d;
    logic          err_q, err_d;
    ramstate_t     rs;
    logic          dreq, grant, expire, cnt_en, cnt_clr;

    assign rs    = ramstate_t'(ramstate);
    assign dreq  = dREN | dWEN;
    assign grant = (state_q == DGRANT) || (state_q == IGRANT);

    // A dropped request outranks ERROR/ACCESS seen in the same cycle.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (dreq)      state_d = DGRANT;
                else if (iREN) state_d = IGRANT;
            end
            DGRANT, IGRANT: begin
                if (!((state_q == DGRANT) ? dreq : iREN)) begin
                    state_d = IDLE;
                end else if (rs == ERROR || (rs != ACCESS && expire)) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (rs == ACCESS) begin
                    state_d = TURN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cnt_en  = grant && (rs != ACCESS);
    assign cnt_clr = !grant || (state_d != state_q);

    memctl_timeout #(
        .LIMIT(TIMEOUT_W'(TIMEOUT))
    ) u_timeout (
        .clk   (CLK),
        .rst_n (nRST),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .expire(expire)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = iREN;
        dwait    = dreq;
        dhit     = 1'b0;
        iload    = '0;
        dload    = '0;
        case (state_q)
            DGRANT: begin
                ramREN   = dREN & ~dWEN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                if (rs == ACCESS && dreq) begin
                    dwait = 1'b0;
                    dhit  = 1'b1;
                    dload = dWEN ? '0 : ramload;
                end
            end
            IGRANT: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                if (rs == ACCESS && iREN) begin
                    iwait = 1'b0;
                    iload = ramload;
                end
            end
            default: ;
        endcase
    end

    assign err = err_q;

endmodule
